// File: rtl/adder_share_arb.sv
// adder_share_arb
// Round-robin arbiter that time-shares one external combinational adder
// between NREQ requesters. The granted operand pair is steered onto the
// adder in the same cycle it is accepted. The adder result is captured in a
// one-entry response register and tagged with the requester index.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_valid  per-requester "operand pair present"
//   req_ready  one-hot (or zero) accept strobe
//   req_a/b    packed operands, requester i at [i*W +: W]
//   add_a/b    operands driven to the shared adder (zero when idle)
//   add_sum    sum returned by the shared adder
//   add_cout   carry-out returned by the shared adder
//   rsp_valid  response register holds an unconsumed result
//   rsp_ready  consumer accepts the result
//   rsp_id     index of the requester that produced the result
//   rsp_sum    registered sum
//   rsp_cout   registered carry-out
//   ovf_cnt    saturating count of accepted results that had carry-out set
//   busy       a result is pending or any requester is valid
module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [7:0]        ovf_cnt,
    output logic              busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [IDW-1:0]   last_grant_r;
    logic [IDW:0]     pick_s;
    logic             can_issue_s;
    logic             grant_s;
    logic [IDW-1:0]   grant_idx_s;

    // Round-robin pick: returns {found, index}. The scan starts just after
    // `last`; iterating from the farthest candidate toward the nearest lets
    // the nearest valid requester overwrite any farther one.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  last);
        logic [IDW:0] result;
        int           cand;
        result = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = int'(last) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end else begin
                cand = cand;
            end
            if (valid[cand]) begin
                result = {1'b1, IDW'(cand)};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    assign rsp_valid   = (state_r == FULL);
    assign busy        = rsp_valid | (|req_valid);
    assign can_issue_s = !rst && (!rsp_valid || rsp_ready);
    assign pick_s      = rr_pick(req_valid, last_grant_r);
    assign grant_s     = can_issue_s && pick_s[IDW];
    assign grant_idx_s = pick_s[IDW-1:0];

    // Grant strobe and operand steering; both are zero whenever no grant issues.
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s && (grant_idx_s == IDW'(i))) begin
                req_ready[i] = 1'b1;
                add_a        = req_a[i*W +: W];
                add_b        = req_b[i*W +: W];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Response-register occupancy: a grant always refills, an accept without
    // a grant drains.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                if (grant_s) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            FULL: begin
                if (grant_s) begin
                    state_next_s = FULL;
                end else if (rsp_ready) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result capture and round-robin pointer; both only move on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sum      <= '0;
            rsp_cout     <= 1'b0;
            rsp_id       <= '0;
            last_grant_r <= IDW'(NREQ - 1);
        end else if (grant_s) begin
            rsp_sum      <= add_sum;
            rsp_cout     <= add_cout;
            rsp_id       <= grant_idx_s;
            last_grant_r <= grant_idx_s;
        end else begin
            rsp_sum      <= rsp_sum;
            rsp_cout     <= rsp_cout;
            rsp_id       <= rsp_id;
            last_grant_r <= last_grant_r;
        end
    end

    // Saturating overflow counter, counted when a carry result is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= 8'd0;
        end else if (rsp_valid && rsp_ready && rsp_cout && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end else begin
            ovf_cnt <= ovf_cnt;
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb. It supplies the shared adder as
// plain arithmetic and compares the DUT, cycle by cycle, against a
// transaction-level model of the arbitration and response rules.
module tb_adder_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_sum;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [7:0]        ovf_cnt;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_valid;
    logic [15:0] m_sum;
    bit          m_cout;
    int          m_id;
    int          m_ovf;
    int          m_last;

    adder_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .ovf_cnt   (ovf_cnt),
        .busy      (busy)
    );

    // Shared combinational adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = 16'h0;
        m_cout  = 1'b0;
        m_id    = 0;
        m_ovf   = 0;
        m_last  = NREQ - 1;
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            set_ops(i, 16'($urandom), 16'($urandom));
        end
    endtask

    // One clock cycle: inputs are already driven. Check the combinational
    // outputs, advance the model, clock, then check the registered outputs.
    task automatic step();
        bit          can;
        bit          found;
        int          g;
        int          c;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [16:0] s;
        #1;
        can   = !rst && (!m_valid || rsp_ready);
        found = 1'b0;
        g     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (m_last + k) % NREQ;
            if (!found && req_valid[c]) begin
                found = 1'b1;
                g     = c;
            end
        end
        ea = (can && found) ? req_a[g*W +: W] : 16'h0;
        eb = (can && found) ? req_b[g*W +: W] : 16'h0;
        chk("req_ready", 32'(req_ready), (can && found) ? (32'd1 << g) : 32'd0);
        chk("add_a", 32'(add_a), 32'(ea));
        chk("add_b", 32'(add_b), 32'(eb));
        chk("busy", 32'(busy), 32'(m_valid || (|req_valid)));
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && rsp_ready && m_cout && m_ovf < 255) m_ovf++;
            if (can && found) begin
                s       = {1'b0, ea} + {1'b0, eb};
                m_sum   = s[15:0];
                m_cout  = s[16];
                m_id    = g;
                m_valid = 1'b1;
                m_last  = g;
            end else if (m_valid && rsp_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
        chk("rsp_cout", 32'(rsp_cout), 32'(m_cout));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        // Reset held: no grants even though everyone is valid
        rand_ops();
        step();
        step();

        // 1: first grant after reset goes to requester 0
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_ops(0, 16'h1234, 16'h0001);
        step();
        chk("t1_sum", 32'(rsp_sum), 32'h1235);
        chk("t1_id", 32'(rsp_id), 32'd0);

        // 2: all requesters valid, one grant per cycle in rotation
        req_valid = 4'b1111;
        for (int n = 0; n < 12; n++) begin
            rand_ops();
            step();
            chk("t2_order", 32'(rsp_id), 32'((n + 1) % NREQ));
        end

        // 3: carry cases from requester 2 (counter cleared first)
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'b0100;
        set_ops(2, 16'hFFFF, 16'h0001);
        step();
        set_ops(2, 16'h8000, 16'h8000);
        step();
        chk("t3_ovf1", 32'(ovf_cnt), 32'd1);
        req_valid = 4'b0000;
        step();
        chk("t3_ovf2", 32'(ovf_cnt), 32'd2);
        step();

        // 4: back-pressure with everyone valid, then release
        req_valid = 4'b1111;
        rand_ops();
        step();
        rsp_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            rand_ops();
            step();
        end
        rsp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            rand_ops();
            step();
        end

        // 5: reset while a result is pending
        rsp_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("t5_valid", 32'(rsp_valid), 32'd0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("t5_first", 32'(rsp_id), 32'd0);

        // 6: 300 carry results drive the counter into saturation
        for (int n = 0; n < 300; n++) begin
            req_valid = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                set_ops(i, 16'hFFFF, 16'($urandom_range(1, 65535)));
            end
            step();
        end
        req_valid = 4'b0000;
        step();
        chk("t6_sat", 32'(ovf_cnt), 32'd255);

        // Random mix of requests, back-pressure and resets
        for (int n = 0; n < 200; n++) begin
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 49) == 0);
            rand_ops();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational 16-bit ripple adder (operands A/B in, 16-bit sum and carry-out back) between NREQ requesters.
- Each requester presents an operand pair under a valid/ready handshake.
- The block steers the granted pair onto the adder, registers sum and carry, and returns them tagged with the requester index under a valid/ready response handshake.
- Throughput is one addition per cycle when the response is not back-pressured.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand/sum width; must match the shared adder.
- IDW, $clog2(NREQ), requester index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high; one clock.
- req_valid  in  NREQ  bit i: requester i has an operand pair.
- req_ready  out  NREQ  one-hot or zero; bit i: pair from requester i accepted this cycle.
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing.
- add_a  out  W  operand A to shared adder.
- add_b  out  W  operand B to shared adder.
- add_sum  in  W  sum from shared adder (combinational in add_a/add_b).
- add_cout  in  1  carry-out from shared adder.
- rsp_valid  out  1  result register holds an unconsumed result.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of requester that produced the result.
- rsp_sum  out  W  registered sum.
- rsp_cout  out  1  registered carry-out.
- ovf_cnt  out  8  saturating count of accepted results with rsp_cout=1.
- busy  out  1  rsp_valid OR any req_valid.

Behaviour:
- State: two-state FSM.
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
  - Also a last_grant register (IDW bits).
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, ovf_cnt=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - req_ready=0 and add_a=add_b=0 while rst=1.
- Grant enable (combinational): can_issue = !rst & (!rsp_valid | rsp_ready).
- Grant selection when can_issue and any req_valid:
  - g = first i with req_valid[i]=1, scanning last_grant+1, last_grant+2, ... modulo NREQ.
  - req_ready = one-hot(g); otherwise req_ready=0.
  - req_ready depends only on req_valid, state and rsp_ready, never on req_a/req_b.
- Operand steering:
  - add_a/add_b = operands of requester g when a grant is issued, else 0.
  - This path is purely combinational; zero added latency to the adder.
- On the clock edge with a grant:
  - rsp_sum<=add_sum, rsp_cout<=add_cout, rsp_id<=g, rsp_valid<=1, last_grant<=g.
- Latency: result visible the cycle after req_valid&req_ready.
- On rsp_valid & rsp_ready with no new grant: rsp_valid<=0. rsp_sum/rsp_cout/rsp_id hold their last values.
- Simultaneous accept and grant: FULL stays FULL and the register reloads with the new result. This sustains 1 op/cycle.
- Back-pressure: while rsp_valid=1 and rsp_ready=0:
  - req_ready=0 and add_a/add_b=0.
  - rsp_* stable and unchanged until accepted.
- ovf_cnt increments on each rsp_valid & rsp_ready with rsp_cout=1 and saturates at 255 (no wrap).
- Wrap-around: after grant to NREQ-1 the search starts at 0.
- Single requester continuously valid: granted every cycle.
- No requester valid: FSM drains only; last_grant unchanged.
- Reset mid-operation: a pending result is discarded (rsp_valid=0 next cycle); an in-flight handshake in the reset cycle is not granted.
- Sum is W bits modulo 2^W; carry-out is solely from the adder.

Test Plan:
1. Reset release, req_valid=0001, req_a[0]=0x1234, req_b[0]=0x0001, rsp_ready=1 -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x1235, rsp_cout=0.
2. All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,... one per cycle; rsp_id sequence matches, with no bubble cycles.
3. Requester 2 adds 0xFFFF+0x0001 -> rsp_sum=0x0000, rsp_cout=1, and ovf_cnt increments to 1 on accept. Next, 0x8000+0x8000 -> 0x0000, cout=1, ovf_cnt=2.
4. rsp_ready=0 for 5 cycles with all requesters valid -> req_ready=0 and rsp_* stable for 5 cycles. On rsp_ready=1, the next round-robin requester is granted that same cycle.
5. Assert rst while rsp_valid=1 -> next cycle rsp_valid=0, ovf_cnt=0, and the first grant afterwards goes to requester 0.
6. Force 300 accepted carry-out results -> ovf_cnt saturates at 255.
